// File: rtl/dot_product_engine.sv
// Multi-lane pipelined dot-product engine: products, lane-sum tree, accumulate, then result hold.
// Optional saturation of the result and the overflow flag are built when DOT_SATURATE_EN is defined.
module dot_product_engine #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned LANES        = 4,
  parameter int unsigned MAX_BEATS    = 16,
  parameter int unsigned BEAT_W       = $clog2(MAX_BEATS) + 1,
  parameter int unsigned RESULT_WIDTH = 2*DATA_WIDTH + $clog2(LANES*MAX_BEATS) + 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [LANES*DATA_WIDTH-1:0] data_from_mem1,
  input  logic [LANES*DATA_WIDTH-1:0] data_from_mem2,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic [BEAT_W-1:0]           vec_len,
  input  logic                        signed_mode,
  output logic [RESULT_WIDTH-1:0]     dot_product_result,
  output logic                        result_valid,
  input  logic                        result_ready,
  output logic                        processing_done,
  output logic                        result_overflow
);

  localparam int unsigned PW = 2*DATA_WIDTH;
`ifdef DOT_SATURATE_EN
  localparam int unsigned ACC_W = RESULT_WIDTH + 1;
`else
  localparam int unsigned ACC_W = RESULT_WIDTH;
`endif

  logic                    run_q, run_d;
  logic                    adv, accept, is_first, is_last, eff_sign;
  logic [BEAT_W-1:0]       cnt_q, cnt_d, len_q, len_d, clamped_len, eff_len;
  logic                    sign_q, sign_d;
  logic [DATA_WIDTH-1:0]   a_l, b_l;
  logic [PW-1:0]           a_x, b_x;
  logic [PW-1:0]           prod_q [LANES];
  logic [PW-1:0]           prod_d [LANES];
  logic                    s1_valid_q, s1_valid_d, s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d, s1_signed_q, s1_signed_d;
  logic [ACC_W-1:0]        lane_sum;
  logic [ACC_W-1:0]        s2_sum_q, s2_sum_d;
  logic                    s2_valid_q, s2_valid_d, s2_first_q, s2_first_d;
  logic                    s2_last_q, s2_last_d, s2_signed_q, s2_signed_d;
  logic [ACC_W-1:0]        acc_q, acc_d;
  logic                    s3_done_q, s3_done_d;
  logic [RESULT_WIDTH-1:0] res_q, res_d, load_val;
  logic                    rv_q, rv_d, done_q, done_d, load_ovf;

  // Whole pipeline stalls only while a finished result waits on the consumer.
  assign adv        = !(rv_q && !result_ready);
  assign data_ready = run_q && adv;
  assign accept     = data_valid && data_ready;

  // Beat counter, per-vector length/mode capture and the product stage.
  always_comb begin
    run_d       = 1'b1;
    cnt_d       = cnt_q;
    len_d       = len_q;
    sign_d      = sign_q;
    a_l         = '0;
    b_l         = '0;
    a_x         = '0;
    b_x         = '0;
    clamped_len = vec_len;
    if (vec_len == '0) begin
      clamped_len = BEAT_W'(1);
    end else if (vec_len > BEAT_W'(MAX_BEATS)) begin
      clamped_len = BEAT_W'(MAX_BEATS);
    end
    is_first = (cnt_q == '0);
    eff_len  = is_first ? clamped_len : len_q;
    eff_sign = is_first ? signed_mode : sign_q;
    is_last  = (cnt_q == BEAT_W'(eff_len - BEAT_W'(1)));
    if (accept) begin
      cnt_d = is_last ? '0 : BEAT_W'(cnt_q + BEAT_W'(1));
      if (is_first) begin
        len_d  = clamped_len;
        sign_d = signed_mode;
      end
    end
    s1_valid_d  = s1_valid_q;
    s1_first_d  = s1_first_q;
    s1_last_d   = s1_last_q;
    s1_signed_d = s1_signed_q;
    for (int i = 0; i < LANES; i++) begin
      prod_d[i] = prod_q[i];
    end
    if (adv) begin
      s1_valid_d  = accept;
      s1_first_d  = is_first;
      s1_last_d   = is_last;
      s1_signed_d = eff_sign;
      // Operands are extended to full product width so one multiplier serves both modes.
      for (int i = 0; i < LANES; i++) begin
        a_l       = data_from_mem1[i*DATA_WIDTH +: DATA_WIDTH];
        b_l       = data_from_mem2[i*DATA_WIDTH +: DATA_WIDTH];
        a_x       = {{DATA_WIDTH{eff_sign & a_l[DATA_WIDTH-1]}}, a_l};
        b_x       = {{DATA_WIDTH{eff_sign & b_l[DATA_WIDTH-1]}}, b_l};
        prod_d[i] = a_x * b_x;
      end
    end
  end

  // Lane-sum tree and accumulator stages.
  always_comb begin
    lane_sum    = '0;
    s2_sum_d    = s2_sum_q;
    s2_valid_d  = s2_valid_q;
    s2_first_d  = s2_first_q;
    s2_last_d   = s2_last_q;
    s2_signed_d = s2_signed_q;
    acc_d       = acc_q;
    s3_done_d   = s3_done_q;
    for (int i = 0; i < LANES; i++) begin
      lane_sum = lane_sum + ACC_W'($signed({s1_signed_q & prod_q[i][PW-1], prod_q[i]}));
    end
    if (adv) begin
      s2_sum_d    = lane_sum;
      s2_valid_d  = s1_valid_q;
      s2_first_d  = s1_first_q;
      s2_last_d   = s1_last_q;
      s2_signed_d = s1_signed_q;
      s3_done_d   = s2_valid_q && s2_last_q;
      if (s2_valid_q) begin
        acc_d = s2_first_q ? s2_sum_q : ACC_W'(acc_q + s2_sum_q);
      end
    end
  end

`ifdef DOT_SATURATE_EN
  logic s3_signed_q, s3_signed_d, ovf_q, ovf_d;

  // Clamp the one-bit-wider accumulator into the result range for the vector's mode.
  always_comb begin
    s3_signed_d = adv ? s2_signed_q : s3_signed_q;
    load_val    = acc_q[RESULT_WIDTH-1:0];
    if (s3_signed_q) begin
      load_ovf = acc_q[ACC_W-1] ^ acc_q[ACC_W-2];
      if (load_ovf) begin
        load_val = acc_q[ACC_W-1] ? {1'b1, {(RESULT_WIDTH-1){1'b0}}}
                                  : {1'b0, {(RESULT_WIDTH-1){1'b1}}};
      end
    end else begin
      load_ovf = acc_q[ACC_W-1];
      if (load_ovf) begin
        load_val = '1;
      end
    end
  end
`else
  logic s2_signed_unused;

  assign s2_signed_unused = s2_signed_q;
  assign load_val         = acc_q;
  assign load_ovf         = 1'b0;
`endif

  // Result hold register and handoff pulse.
  always_comb begin
    res_d  = res_q;
    rv_d   = rv_q && !result_ready;
    done_d = rv_q && result_ready;
    if (adv && s3_done_q) begin
      res_d = load_val;
      rv_d  = 1'b1;
    end
  end

`ifdef DOT_SATURATE_EN
  assign ovf_d = (adv && s3_done_q) ? load_ovf : ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s3_signed_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      s3_signed_q <= s3_signed_d;
      ovf_q       <= ovf_d;
    end
  end

  assign result_overflow = ovf_q;
`else
  logic load_ovf_unused;

  assign load_ovf_unused = load_ovf;
  assign result_overflow = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q       <= 1'b0;
      cnt_q       <= '0;
      len_q       <= '0;
      sign_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= '0;
      end
      s1_valid_q  <= 1'b0;
      s1_first_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_signed_q <= 1'b0;
      s2_sum_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_first_q  <= 1'b0;
      s2_last_q   <= 1'b0;
      s2_signed_q <= 1'b0;
      acc_q       <= '0;
      s3_done_q   <= 1'b0;
      res_q       <= '0;
      rv_q        <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      run_q       <= run_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sign_q      <= sign_d;
      for (int i = 0; i < LANES; i++) begin
        prod_q[i] <= prod_d[i];
      end
      s1_valid_q  <= s1_valid_d;
      s1_first_q  <= s1_first_d;
      s1_last_q   <= s1_last_d;
      s1_signed_q <= s1_signed_d;
      s2_sum_q    <= s2_sum_d;
      s2_valid_q  <= s2_valid_d;
      s2_first_q  <= s2_first_d;
      s2_last_q   <= s2_last_d;
      s2_signed_q <= s2_signed_d;
      acc_q       <= acc_d;
      s3_done_q   <= s3_done_d;
      res_q       <= res_d;
      rv_q        <= rv_d;
      done_q      <= done_d;
    end
  end

  assign dot_product_result = res_q;
  assign result_valid       = rv_q;
  assign processing_done    = done_q;

endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: vector table plus directed latency, backpressure, reset and width cases.
// A second instance with a 12-bit result covers wrap/saturation (DOT_SATURATE_EN).
module tb_dot_product_engine;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_from_mem1, data_from_mem2;
  logic        data_valid;
  logic [4:0]  vec_len;
  logic        signed_mode;
  logic        result_ready;
  logic        data_ready, result_valid, processing_done, result_overflow;
  logic [22:0] dot_product_result;
  logic        dr12, rv12, done12, ovf12;
  logic [11:0] res12;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [22:0] res;
    logic        ovf;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [4:0]  len;
    logic        sm;
    int          nb;
    logic [63:0] a;
    logic [63:0] b;
    logic [22:0] exp;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  dot_product_engine u_dut (
    .clk(clk), .rst_n(rst_n),
    .data_from_mem1(data_from_mem1), .data_from_mem2(data_from_mem2),
    .data_valid(data_valid), .data_ready(data_ready),
    .vec_len(vec_len), .signed_mode(signed_mode),
    .dot_product_result(dot_product_result), .result_valid(result_valid),
    .result_ready(result_ready), .processing_done(processing_done),
    .result_overflow(result_overflow)
  );

  dot_product_engine #(.RESULT_WIDTH(12)) u_dut12 (
    .clk(clk), .rst_n(rst_n),
    .data_from_mem1(data_from_mem1), .data_from_mem2(data_from_mem2),
    .data_valid(data_valid), .data_ready(dr12),
    .vec_len(vec_len), .signed_mode(signed_mode),
    .dot_product_result(res12), .result_valid(rv12),
    .result_ready(result_ready), .processing_done(done12),
    .result_overflow(ovf12)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] len, input logic sm, input int nb,
                              input logic [31:0] a0, input logic [31:0] b0,
                              input logic [31:0] a1, input logic [31:0] b1, input int e);
    vec_t v;
    v.len = len; v.sm = sm; v.nb = nb;
    v.a = {a1, a0}; v.b = {b1, b0};
    v.exp = 23'(e);
    return v;
  endfunction

  // Result monitor: pops the scoreboard on every handoff and checks the done pulse.
  logic prev_hs = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_hs = 1'b0;
    end else begin
      check("done_pulse", 32'(processing_done), 32'(prev_hs));
      check("twin_ctrl", {30'd0, dr12, done12}, {30'd0, data_ready, processing_done});
      prev_hs = result_valid && result_ready;
      if (result_valid && result_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_result", 32'(dot_product_result), 32'hFFFF_FFFF);
        end else begin
          e = sb.pop_front();
          check("result", 32'(dot_product_result), 32'(e.res));
          check("overflow", 32'(result_overflow), 32'(e.ovf));
        end
      end
    end
  end

  task automatic send_beat(input logic [31:0] a, input logic [31:0] b,
                           input logic [4:0] len, input logic sm);
    int guard = 0;
    data_from_mem1 = a; data_from_mem2 = b;
    vec_len = len; signed_mode = sm; data_valid = 1'b1;
    @(negedge clk);
    while (!data_ready && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (!data_ready) check("accept_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    data_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t v);
    for (int j = 0; j < v.nb; j++) begin
      if (j == v.nb - 1) sb.push_back({v.exp, 1'b0});
      send_beat(v.a[j*32 +: 32], v.b[j*32 +: 32], v.len, v.sm);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_data_ready"}, 32'(data_ready), 32'd0);
    check({tag, "_result_valid"}, 32'(result_valid), 32'd0);
    check({tag, "_result"}, 32'(dot_product_result), 32'd0);
    check({tag, "_done"}, 32'(processing_done), 32'd0);
    check({tag, "_overflow"}, 32'(result_overflow), 32'd0);
  endtask

  initial begin
    int g;
    tbl[0] = mk(5'd1, 1'b0, 1, 32'h04030201, 32'h01010101, 32'h0, 32'h0, 10);
    tbl[1] = mk(5'd2, 1'b0, 2, 32'h08060402, 32'h04030201, 32'hFFFFFFFF, 32'h01010101, 1080);
    tbl[2] = mk(5'd1, 1'b1, 1, 32'h04FD02FF, 32'h05050505, 32'h0, 32'h0, 10);
    tbl[3] = mk(5'd1, 1'b0, 1, 32'h04FD02FF, 32'h05050505, 32'h0, 32'h0, 2570);
    tbl[4] = mk(5'd2, 1'b1, 2, 32'h80808080, 32'h7F7F7F7F, 32'hFFFFFFFF, 32'h01010101, -65028);
    tbl[5] = mk(5'd0, 1'b0, 1, 32'h01010101, 32'h02020202, 32'h0, 32'h0, 8);
    tbl[6] = mk(5'd2, 1'b1, 2, 32'h7F7F7F7F, 32'h7F7F7F7F, 32'h80808080, 32'h80808080, 130052);

    rst_n = 1'b0; data_valid = 1'b0; data_from_mem1 = '0; data_from_mem2 = '0;
    vec_len = '0; signed_mode = 1'b0; result_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_zero_outputs("reset");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_reset", 32'(data_ready), 32'd1);

    // First result: three-cycle latency after the accepting edge.
    sb.push_back({23'd10, 1'b0});
    send_beat(32'h04030201, 32'h01010101, 5'd1, 1'b0);
    check("latency_c0", 32'(result_valid), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      check($sformatf("latency_c%0d", c), 32'(result_valid), (c == 3) ? 32'd1 : 32'd0);
    end
    check("latency_value", 32'(dot_product_result), 32'd10);
    drain();

    foreach (tbl[i]) send_vec(tbl[i]);
    drain();

    // Over-long vec_len clamps to 16 beats; the following vector must start fresh.
    sb.push_back({23'd64, 1'b0});
    for (int j = 0; j < 16; j++) send_beat(32'h01010101, 32'h01010101, 5'd31, 1'b0);
    sb.push_back({23'd10, 1'b0});
    send_beat(32'h04030201, 32'h01010101, 5'd1, 1'b0);
    drain();

    // Backpressure: two results queued behind a stalled consumer.
    result_ready = 1'b0;
    sb.push_back({23'd10, 1'b0});
    send_beat(32'h04030201, 32'h01010101, 5'd1, 1'b0);
    sb.push_back({23'd60, 1'b0});
    send_beat(32'h08060402, 32'h04030201, 5'd1, 1'b0);
    g = 0;
    while (!result_valid && g < 20) begin
      @(posedge clk); #1;
      g++;
    end
    for (int c = 0; c < 5; c++) begin
      check("stall_ready_low", 32'(data_ready), 32'd0);
      check("stall_hold_valid", 32'(result_valid), 32'd1);
      check("stall_hold_value", 32'(dot_product_result), 32'd10);
      @(posedge clk); #1;
    end
    result_ready = 1'b1;
    drain();

    // Reset in the middle of a two-beat vector discards the partial sum.
    send_beat(32'h01010101, 32'h01010101, 5'd2, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1 check_zero_outputs("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    sb.push_back({23'd4, 1'b0});
    send_beat(32'h01010101, 32'h01010101, 5'd1, 1'b0);
    drain();

    // Narrow result instance: wrap or saturate depending on build.
    sb.push_back({23'd260100, 1'b0});
    send_beat(32'hFFFFFFFF, 32'hFFFFFFFF, 5'd1, 1'b0);
    g = 0;
    while (!rv12 && g < 20) begin
      @(negedge clk);
      g++;
    end
    check("narrow_valid", 32'(rv12), 32'd1);
`ifdef DOT_SATURATE_EN
    check("narrow_result", 32'(res12), 32'd4095);
    check("narrow_overflow", 32'(ovf12), 32'd1);
`else
    check("narrow_result", 32'(res12), 32'd2052);
    check("narrow_overflow", 32'(ovf12), 32'd0);
`endif
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
